// File: rtl/adc_sched_pkg.sv
// Shared widths, defaults and FSM state encoding for the ADC scheduler.
package adc_sched_pkg;

   localparam int GAIN_W         = 4;
   localparam int AMP_W          = 8;
   localparam int ADC_W          = 14;
   localparam int ACC_W          = 16;
   localparam int MIN_PERIOD_DEF = 100;

   typedef enum logic [2:0] {
      IDLE,
      AMP_LOAD,
      AMP_WAIT,
      WAIT_TICK,
      CONV,
      CONV_WAIT
   } state_t;

endpackage

// File: rtl/adc_tick_gen.sv
// Free-running sample-period counter; emits a one-cycle tick at count P-1.
// reset is active-low and asynchronous, shared with the scheduler top.
module adc_tick_gen
   import adc_sched_pkg::*;
#(
   parameter int PERIOD_W   = 16,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

   logic [PERIOD_W-1:0] count_q, count_d;
   logic [PERIOD_W-1:0] len_q, len_d;
   logic [PERIOD_W-1:0] len_cur;

   // The period is taken from the input only at count 0, so a change
   // mid-period takes effect at the next wrap.
   always_comb begin
      len_cur = len_q;
      if (count_q == '0) begin
         len_cur = (period < MIN_P) ? MIN_P : period;
      end
      tick    = enable && (count_q == (len_cur - PERIOD_W'(1)));
      len_d   = len_cur;
      count_d = count_q + PERIOD_W'(1);
      if (!enable || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         len_q   <= '0;
      end else begin
         count_q <= count_d;
         len_q   <= len_d;
      end
   end

endmodule

// File: rtl/adc_scheduler.sv
// Periodic two-channel ADC sampler that programs the preamp gain before converting.
// Define ADC_SCHED_AVG_EN to report the average of every four conversions.
module adc_scheduler
   import adc_sched_pkg::*;
#(
   parameter int PERIOD_W   = 16,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                CLK50MHZ,
   input  logic                RST,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [GAIN_W-1:0]   gain_a,
   input  logic [GAIN_W-1:0]   gain_b,
   input  logic                gain_load,
   output logic                amp_trig,
   output logic [AMP_W-1:0]    amp_data,
   input  logic                amp_done,
   output logic                adc_trig,
   input  logic                adc_done,
   input  logic [ADC_W-1:0]    adc_a,
   input  logic [ADC_W-1:0]    adc_b,
   output logic                sample_valid,
   output logic [ADC_W-1:0]    sample_a,
   output logic [ADC_W-1:0]    sample_b,
   output logic                busy,
   output logic                overrun
);

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   logic   overrun_q, overrun_d;
   logic   sample_valid_q, sample_valid_d;
   logic [AMP_W-1:0] amp_data_q, amp_data_d;
   logic [ADC_W-1:0] sample_a_q, sample_a_d;
   logic [ADC_W-1:0] sample_b_q, sample_b_d;
   logic   tick;
   logic   reload;
   logic   capture;
   logic   tick_taken;

   adc_tick_gen #(
      .PERIOD_W   (PERIOD_W),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_tick_gen (
      .clock  (CLK50MHZ),
      .reset  (RST),
      .enable (enable),
      .period (period),
      .tick   (tick)
   );

   // A started SPI transfer is always allowed to finish; enable falling only
   // redirects the FSM to IDLE once the matching done arrives.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q | gain_load;
      amp_data_d = amp_data_q;
      overrun_d  = overrun_q;
      reload     = 1'b0;
      capture    = 1'b0;
      tick_taken = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) reload = 1'b1;
         end
         AMP_LOAD: begin
            state_d = AMP_WAIT;
         end
         AMP_WAIT: begin
            if (amp_done) state_d = enable ? WAIT_TICK : IDLE;
         end
         WAIT_TICK: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (pending_q || gain_load) begin
               reload = 1'b1;
            end else if (tick) begin
               state_d    = CONV;
               tick_taken = 1'b1;
            end
         end
         CONV: begin
            state_d = CONV_WAIT;
         end
         CONV_WAIT: begin
            if (adc_done) begin
               state_d = enable ? WAIT_TICK : IDLE;
               capture = enable;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (reload) begin
         state_d    = AMP_LOAD;
         amp_data_d = {gain_b, gain_a};
         pending_d  = 1'b0;
      end
      if (tick && !tick_taken) overrun_d = 1'b1;
      if (!enable) overrun_d = 1'b0;
   end

`ifdef ADC_SCHED_AVG_EN
   logic [ACC_W-1:0] acc_a_q, acc_a_d;
   logic [ACC_W-1:0] acc_b_q, acc_b_d;
   logic [1:0]       avg_cnt_q, avg_cnt_d;
   logic [ACC_W-1:0] sum_a;
   logic [ACC_W-1:0] sum_b;

   // Bits [15:2] of the 16-bit sum are the arithmetic divide-by-four.
   always_comb begin
      sum_a          = acc_a_q + {{(ACC_W-ADC_W){adc_a[ADC_W-1]}}, adc_a};
      sum_b          = acc_b_q + {{(ACC_W-ADC_W){adc_b[ADC_W-1]}}, adc_b};
      acc_a_d        = acc_a_q;
      acc_b_d        = acc_b_q;
      avg_cnt_d      = avg_cnt_q;
      sample_valid_d = 1'b0;
      sample_a_d     = sample_a_q;
      sample_b_d     = sample_b_q;
      if (!enable || reload) begin
         acc_a_d   = '0;
         acc_b_d   = '0;
         avg_cnt_d = '0;
      end else if (capture) begin
         if (avg_cnt_q == 2'd3) begin
            sample_valid_d = 1'b1;
            sample_a_d     = sum_a[ACC_W-1:2];
            sample_b_d     = sum_b[ACC_W-1:2];
            acc_a_d        = '0;
            acc_b_d        = '0;
            avg_cnt_d      = '0;
         end else begin
            acc_a_d   = sum_a;
            acc_b_d   = sum_b;
            avg_cnt_d = avg_cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         acc_a_q   <= '0;
         acc_b_q   <= '0;
         avg_cnt_q <= '0;
      end else begin
         acc_a_q   <= acc_a_d;
         acc_b_q   <= acc_b_d;
         avg_cnt_q <= avg_cnt_d;
      end
   end
`else
   always_comb begin
      sample_valid_d = capture;
      sample_a_d     = sample_a_q;
      sample_b_d     = sample_b_q;
      if (capture) begin
         sample_a_d = adc_a;
         sample_b_d = adc_b;
      end
   end
`endif

   always_ff @(posedge CLK50MHZ or negedge RST) begin
      if (!RST) begin
         state_q        <= IDLE;
         pending_q      <= 1'b0;
         overrun_q      <= 1'b0;
         amp_data_q     <= '0;
         sample_valid_q <= 1'b0;
         sample_a_q     <= '0;
         sample_b_q     <= '0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         overrun_q      <= overrun_d;
         amp_data_q     <= amp_data_d;
         sample_valid_q <= sample_valid_d;
         sample_a_q     <= sample_a_d;
         sample_b_q     <= sample_b_d;
      end
   end

   assign amp_trig     = (state_q == AMP_LOAD);
   assign adc_trig     = (state_q == CONV);
   assign busy         = (state_q != IDLE) && (state_q != WAIT_TICK);
   assign amp_data     = amp_data_q;
   assign sample_valid = sample_valid_q;
   assign sample_a     = sample_a_q;
   assign sample_b     = sample_b_q;
   assign overrun      = overrun_q;

endmodule
